// File: rtl/lsq_mem_issue.sv
// rtl/lsq_mem_issue.sv - LSQ head issue to data memory with CDB completion broadcast
module lsq_mem_issue #(
    parameter int ROB_IDX_BITS = 5,
    parameter int PREG_BITS    = 6
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    mispredict_i,
    input  logic                    lsq_empty_i,
    input  logic                    head_ready_i,
    input  logic                    head_is_store_i,
    input  logic [2:0]              head_funct3_i,
    input  logic [31:0]             head_addr_i,
    input  logic [31:0]             head_wdata_i,
    input  logic [ROB_IDX_BITS-1:0] head_rob_idx_i,
    input  logic [PREG_BITS-1:0]    head_pd_i,
    input  logic [ROB_IDX_BITS-1:0] rob_head_idx_i,
    output logic                    arbiter_pop_o,
    output logic [31:0]             dmem_addr_o,
    output logic [3:0]              dmem_rmask_o,
    output logic [3:0]              dmem_wmask_o,
    output logic [31:0]             dmem_wdata_o,
    input  logic [31:0]             dmem_rdata_i,
    input  logic                    dmem_resp_i,
    output logic                    cdb_valid_o,
    output logic [ROB_IDX_BITS-1:0] cdb_rob_idx_o,
    output logic [PREG_BITS-1:0]    cdb_pd_o,
    output logic [31:0]             cdb_data_o,
    output logic                    cdb_misaligned_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DONE  = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic                    is_store_q, is_store_d;
    logic [2:0]              funct3_q, funct3_d;
    logic [1:0]              off_q, off_d;
    logic [ROB_IDX_BITS-1:0] rob_q, rob_d;
    logic [PREG_BITS-1:0]    pd_q, pd_d;

    logic [31:0]             addr_q, addr_d;
    logic [3:0]              rmask_q, rmask_d;
    logic [3:0]              wmask_q, wmask_d;
    logic [31:0]             wdata_q, wdata_d;
    logic                    cdb_valid_q, cdb_valid_d;
    logic [ROB_IDX_BITS-1:0] cdb_rob_q, cdb_rob_d;
    logic [PREG_BITS-1:0]    cdb_pd_q, cdb_pd_d;
    logic [31:0]             cdb_data_q, cdb_data_d;
    logic                    cdb_mis_q, cdb_mis_d;

    logic [1:0]  head_size;
    logic [1:0]  head_off;
    logic        head_misaligned;
    logic [3:0]  head_mask;
    logic        issue;
    logic [31:0] rdata_shifted;
    logic [31:0] load_value;

    assign head_size = head_funct3_i[1:0];
    assign head_off  = head_addr_i[1:0];

    // Halfwords need an even address; words (and the unused size 3) need a word-aligned one.
    assign head_misaligned = ((head_size == 2'b01) && head_off[0]) ||
                             (head_size[1] && (head_off != 2'b00));

    // Byte-lane enables for the head access, shifted to its lane offset.
    always_comb begin
        head_mask = 4'b0000;
        case (head_size)
            2'b00:   head_mask = 4'b0001 << head_off;
            2'b01:   head_mask = 4'b0011 << head_off;
            default: head_mask = 4'b1111;
        endcase
    end

    // Stores wait for the ROB head so that memory is never written speculatively.
    assign issue = (state_q == ST_IDLE) && !lsq_empty_i && head_ready_i && !mispredict_i &&
                   (!head_is_store_i || (head_rob_idx_i == rob_head_idx_i));

    // The pop is combinational, so it is masked while reset is held to keep it low asynchronously.
    assign arbiter_pop_o = issue && rst_ni;

    // Align the returned word to the accessed lane, then extend per the latched load type.
    always_comb begin
        rdata_shifted = dmem_rdata_i >> {off_q, 3'b000};
        load_value    = rdata_shifted;
        case (funct3_q)
            3'b000:  load_value = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
            3'b001:  load_value = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
            3'b100:  load_value = {24'd0, rdata_shifted[7:0]};
            3'b101:  load_value = {16'd0, rdata_shifted[15:0]};
            default: load_value = rdata_shifted;
        endcase
    end

    // Next-state and registered-output logic for the issue FSM.
    always_comb begin
        state_d     = state_q;
        is_store_d  = is_store_q;
        funct3_d    = funct3_q;
        off_d       = off_q;
        rob_d       = rob_q;
        pd_d        = pd_q;
        addr_d      = addr_q;
        rmask_d     = rmask_q;
        wmask_d     = wmask_q;
        wdata_d     = wdata_q;
        cdb_valid_d = 1'b0;
        cdb_rob_d   = cdb_rob_q;
        cdb_pd_d    = cdb_pd_q;
        cdb_data_d  = cdb_data_q;
        cdb_mis_d   = cdb_mis_q;

        case (state_q)
            ST_IDLE: begin
                if (issue) begin
                    is_store_d = head_is_store_i;
                    funct3_d   = head_funct3_i;
                    off_d      = head_off;
                    rob_d      = head_rob_idx_i;
                    pd_d       = head_pd_i;
                    if (head_misaligned) begin
                        // No memory access; report the fault on the next cycle.
                        cdb_valid_d = 1'b1;
                        cdb_rob_d   = head_rob_idx_i;
                        cdb_pd_d    = head_is_store_i ? '0 : head_pd_i;
                        cdb_data_d  = 32'd0;
                        cdb_mis_d   = 1'b1;
                        state_d     = ST_DONE;
                    end else begin
                        addr_d  = {head_addr_i[31:2], 2'b00};
                        rmask_d = head_is_store_i ? 4'b0000 : head_mask;
                        wmask_d = head_is_store_i ? head_mask : 4'b0000;
                        wdata_d = head_is_store_i ? (head_wdata_i << {head_off, 3'b000}) : 32'd0;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (dmem_resp_i) begin
                    rmask_d = 4'b0000;
                    wmask_d = 4'b0000;
                    if (mispredict_i) begin
                        state_d = ST_IDLE;
                    end else begin
                        cdb_valid_d = 1'b1;
                        cdb_rob_d   = rob_q;
                        cdb_pd_d    = is_store_q ? '0 : pd_q;
                        cdb_data_d  = is_store_q ? 32'd0 : load_value;
                        cdb_mis_d   = 1'b0;
                        state_d     = ST_DONE;
                    end
                end else if (mispredict_i) begin
                    // The request must still be seen through by memory; only the broadcast is dropped.
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_DRAIN: begin
                if (dmem_resp_i) begin
                    rmask_d = 4'b0000;
                    wmask_d = 4'b0000;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any outstanding request.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            is_store_q  <= 1'b0;
            funct3_q    <= 3'b000;
            off_q       <= 2'b00;
            rob_q       <= '0;
            pd_q        <= '0;
            addr_q      <= 32'd0;
            rmask_q     <= 4'b0000;
            wmask_q     <= 4'b0000;
            wdata_q     <= 32'd0;
            cdb_valid_q <= 1'b0;
            cdb_rob_q   <= '0;
            cdb_pd_q    <= '0;
            cdb_data_q  <= 32'd0;
            cdb_mis_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            is_store_q  <= is_store_d;
            funct3_q    <= funct3_d;
            off_q       <= off_d;
            rob_q       <= rob_d;
            pd_q        <= pd_d;
            addr_q      <= addr_d;
            rmask_q     <= rmask_d;
            wmask_q     <= wmask_d;
            wdata_q     <= wdata_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_rob_q   <= cdb_rob_d;
            cdb_pd_q    <= cdb_pd_d;
            cdb_data_q  <= cdb_data_d;
            cdb_mis_q   <= cdb_mis_d;
        end
    end

    assign dmem_addr_o      = addr_q;
    assign dmem_rmask_o     = rmask_q;
    assign dmem_wmask_o     = wmask_q;
    assign dmem_wdata_o     = wdata_q;
    assign cdb_valid_o      = cdb_valid_q;
    assign cdb_rob_idx_o    = cdb_rob_q;
    assign cdb_pd_o         = cdb_pd_q;
    assign cdb_data_o       = cdb_data_q;
    assign cdb_misaligned_o = cdb_mis_q;

endmodule
